// File: rtl/frame_scan_pkg.sv
// Shared types and defaults for the raster scan scheduler.
// Also used by any stage that needs the scan state encoding.
package frame_scan_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } scan_state_e;

   localparam int unsigned IMG_W_DEF   = 256;
   localparam int unsigned IMG_H_DEF   = 256;
   localparam int unsigned DIV_DEF     = 4;
   localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/clk_en_div.sv
// Clock-enable divider: pulses en once every DIV cycles of CLK.
// clr restarts the count at 0; hold freezes it.
module clk_en_div #(
   parameter int unsigned DIV = 4
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic clr,
   input  logic hold,
   output logic en
);

   localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

   logic [CntW-1:0] cnt;
   logic            wrap;

   always_comb begin
      wrap = (cnt == CntMax);
      en   = wrap & ~hold & ~clr;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (!hold) begin
         cnt <= wrap ? '0 : cnt + CntW'(1);
      end
   end

endmodule

// File: rtl/frame_scan_ctrl.sv
// Raster scan scheduler: walks COL/ROW over one frame per START and offers
// each coordinate downstream via PIX_VALID/PIX_READY, paced by clk_en_div.
module frame_scan_ctrl
   import frame_scan_pkg::*;
#(
   parameter int unsigned IMG_W = IMG_W_DEF,
   parameter int unsigned IMG_H = IMG_H_DEF,
   parameter int unsigned DIV   = DIV_DEF,
   parameter int unsigned CW    = $clog2(IMG_W),
   parameter int unsigned RW    = $clog2(IMG_H)
) (
   input  logic                   CLK,
   input  logic                   RST_N,
   input  logic                   START,
   input  logic                   ABORT,
   input  logic                   PIX_READY,
   output logic                   PIX_VALID,
   output logic [CW-1:0]          COL,
   output logic [RW-1:0]          ROW,
   output logic                   SOF,
   output logic                   EOL,
   output logic                   EOF,
   output logic                   BUSY,
   output logic                   DONE,
   output logic [FRAME_CNT_W-1:0] FRAME_CNT
);

   localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
   localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

   scan_state_e   state;
   logic          en, clr, hold, xfer;
   logic          last_col, last_row, cur_sof;
   logic          nxt_eol, nxt_eof;
   logic [CW-1:0] col_nxt;
   logic [RW-1:0] row_nxt;

   always_comb begin
      xfer     = PIX_VALID & PIX_READY;
      hold     = PIX_VALID & ~PIX_READY;
      clr      = (state != RUN) | ABORT;
      last_col = (COL == ColLast);
      last_row = (ROW == RowLast);
      cur_sof  = (COL == '0) && (ROW == '0);
      col_nxt  = last_col ? '0 : COL + CW'(1);
      row_nxt  = last_col ? ROW + RW'(1) : ROW;
      nxt_eol  = (col_nxt == ColLast);
      nxt_eof  = nxt_eol && (row_nxt == RowLast);
   end

   clk_en_div #(
      .DIV (DIV)
   ) u_div (
      .CLK   (CLK),
      .RST_N (RST_N),
      .clr   (clr),
      .hold  (hold),
      .en    (en)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         PIX_VALID <= 1'b0;
         COL       <= '0;
         ROW       <= '0;
         SOF       <= 1'b0;
         EOL       <= 1'b0;
         EOF       <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         FRAME_CNT <= '0;
      end else begin
         DONE <= 1'b0;
         if (ABORT && state != IDLE) begin
            // A transfer coinciding with ABORT is dropped, not completed.
            state     <= IDLE;
            BUSY      <= 1'b0;
            PIX_VALID <= 1'b0;
            SOF       <= 1'b0;
            EOL       <= 1'b0;
            EOF       <= 1'b0;
            COL       <= '0;
            ROW       <= '0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (START && !ABORT) begin
                     state <= RUN;
                     BUSY  <= 1'b1;
                     COL   <= '0;
                     ROW   <= '0;
                  end
               end
               RUN: begin
                  if (xfer) begin
                     if (EOF) begin
                        state     <= FIN;
                        PIX_VALID <= 1'b0;
                        SOF       <= 1'b0;
                        EOL       <= 1'b0;
                        EOF       <= 1'b0;
                        DONE      <= 1'b1;
                        FRAME_CNT <= FRAME_CNT + FRAME_CNT_W'(1);
                     end else begin
                        // en can only coincide with a transfer when DIV=1.
                        COL       <= col_nxt;
                        ROW       <= row_nxt;
                        PIX_VALID <= en;
                        SOF       <= 1'b0;
                        EOL       <= en & nxt_eol;
                        EOF       <= en & nxt_eof;
                     end
                  end else if (!PIX_VALID && en) begin
                     PIX_VALID <= 1'b1;
                     SOF       <= cur_sof;
                     EOL       <= last_col;
                     EOF       <= last_col & last_row;
                  end
               end
               FIN: begin
                  state <= IDLE;
                  BUSY  <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_frame_scan_ctrl.sv
// Directed bench for frame_scan_ctrl on a 4x2 frame, with DIV=1 and DIV=4 instances.
module tb_frame_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start1, abort1, ready1;
   logic        start4, abort4, ready4;
   logic        valid1, sof1, eol1, eof1, busy1, done1;
   logic        valid4, sof4, eol4, eof4, busy4, done4;
   logic [1:0]  col1, col4;
   logic [0:0]  row1, row4;
   logic [15:0] fcnt1, fcnt4;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   frame_scan_ctrl #(.IMG_W(4), .IMG_H(2), .DIV(1)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .START(start1), .ABORT(abort1), .PIX_READY(ready1),
      .PIX_VALID(valid1), .COL(col1), .ROW(row1), .SOF(sof1), .EOL(eol1), .EOF(eof1),
      .BUSY(busy1), .DONE(done1), .FRAME_CNT(fcnt1)
   );

   frame_scan_ctrl #(.IMG_W(4), .IMG_H(2), .DIV(4)) u_dut4 (
      .CLK(clk), .RST_N(rst_n), .START(start4), .ABORT(abort4), .PIX_READY(ready4),
      .PIX_VALID(valid4), .COL(col4), .ROW(row4), .SOF(sof4), .EOL(eol4), .EOF(eof4),
      .BUSY(busy4), .DONE(done4), .FRAME_CNT(fcnt4)
   );

   // Packed layout: {valid,sof,eol,eof,busy,done,2'b0,col[3:0],row[3:0],frame_cnt[15:0]}
   function automatic logic [31:0] mk(input logic v, input logic s, input logic el,
                                      input logic ef, input logic b, input logic d,
                                      input int c, input int r, input int f);
      return {v, s, el, ef, b, d, 2'b00, 4'(c), 4'(r), 16'(f)};
   endfunction

   function automatic logic [31:0] snap1();
      return {valid1, sof1, eol1, eof1, busy1, done1, 2'b00, 4'(col1), 4'(row1), fcnt1};
   endfunction

   function automatic logic [31:0] snap4();
      return {valid4, sof4, eol4, eof4, busy4, done4, 2'b00, 4'(col4), 4'(row4), fcnt4};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Pixel k of the 4x2 frame on offer.
   task automatic chk_pix(input string tag, input logic [31:0] obs, input int k, input int f);
      chk(tag, obs, mk(1'b1, k == 0, (k % 4) == 3, k == 7, 1'b1, 1'b0, k % 4, k / 4, f));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int idx;
      rst_n  = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; ready1 = 1'b1;
      start4 = 1'b0; abort4 = 1'b0; ready4 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dut1", snap1(), 32'h0);
      chk("rst_dut4", snap4(), 32'h0);
      #3 rst_n = 1'b1;
      tick(); tick();
      chk("idle_after_rst", snap1(), 32'h0);

      // DIV=1, always ready: back-to-back slots cycles 1..8
      start1 = 1'b1; tick(); start1 = 1'b0;
      chk("div1_c0", snap1(), mk(0, 0, 0, 0, 1, 0, 0, 0, 0));
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_pix("div1_pix", snap1(), k, 0);
      end
      tick();
      chk("div1_done", snap1(), mk(0, 0, 0, 0, 1, 1, 3, 1, 1));
      tick();
      chk("div1_idle", snap1(), mk(0, 0, 0, 0, 0, 0, 3, 1, 1));

      // DIV=4: one slot every 4 cycles, DONE at cycle 33
      start4 = 1'b1; tick(); start4 = 1'b0;
      for (int c = 1; c <= 34; c++) begin
         tick();
         if (c % 4 == 0 && c <= 32) begin
            chk_pix("div4_pix", snap4(), c / 4 - 1, 0);
         end else if (c == 33) begin
            chk("div4_done", snap4(), mk(0, 0, 0, 0, 1, 1, 3, 1, 1));
         end else if (c == 34) begin
            chk("div4_idle", snap4(), mk(0, 0, 0, 0, 0, 0, 3, 1, 1));
         end else begin
            idx = c / 4;
            chk("div4_gap", snap4(), mk(0, 0, 0, 0, 1, 0, idx % 4, idx / 4, 0));
         end
      end

      // Backpressure on pixel (2,0): held 4 cycles, nothing skipped
      start1 = 1'b1; tick(); start1 = 1'b0;
      tick(); chk_pix("bp_pix", snap1(), 0, 1);
      tick(); chk_pix("bp_pix", snap1(), 1, 1);
      tick(); chk_pix("bp_stall", snap1(), 2, 1);
      ready1 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_pix("bp_stall", snap1(), 2, 1);
      end
      ready1 = 1'b1;
      for (int k = 3; k < 8; k++) begin
         tick();
         chk_pix("bp_pix", snap1(), k, 1);
      end
      tick();
      chk("bp_done", snap1(), mk(0, 0, 0, 0, 1, 1, 3, 1, 2));
      tick();

      // ABORT while (1,1) is on offer
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk_pix("ab_pix", snap1(), k, 2);
      end
      abort1 = 1'b1; tick(); abort1 = 1'b0;
      chk("ab_after", snap1(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("ab_no_done", snap1(), mk(0, 0, 0, 0, 0, 0, 0, 0, 2));
      end
      start1 = 1'b1; tick(); start1 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_pix("rescan_pix", snap1(), k, 2);
      end
      tick();
      chk("rescan_done", snap1(), mk(0, 0, 0, 0, 1, 1, 3, 1, 3));
      tick();

      // START+ABORT in IDLE, then START held while BUSY
      start1 = 1'b1; abort1 = 1'b1; tick(); start1 = 1'b0; abort1 = 1'b0;
      chk("sa_idle", snap1(), mk(0, 0, 0, 0, 0, 0, 3, 1, 3));
      tick();
      chk("sa_idle2", snap1(), mk(0, 0, 0, 0, 0, 0, 3, 1, 3));
      start1 = 1'b1; tick();
      for (int k = 0; k < 8; k++) begin
         tick();
         chk_pix("rep_pix", snap1(), k, 3);
         if (k == 4) start1 = 1'b0;
      end
      tick();
      chk("rep_done", snap1(), mk(0, 0, 0, 0, 1, 1, 3, 1, 4));
      tick();
      chk("rep_idle", snap1(), mk(0, 0, 0, 0, 0, 0, 3, 1, 4));
      tick();
      chk("rep_one_frame", snap1(), mk(0, 0, 0, 0, 0, 0, 3, 1, 4));

      // Asynchronous reset mid-frame, between clock edges
      start1 = 1'b1; tick(); start1 = 1'b0;
      tick(); tick(); tick();
      chk_pix("pre_rst_pix", snap1(), 2, 4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst1", snap1(), 32'h0);
      chk("async_rst4", snap4(), 32'h0);
      #2 rst_n = 1'b1;
      tick(); tick();
      chk("post_rst_idle", snap1(), 32'h0);
      start1 = 1'b1; tick(); start1 = 1'b0;
      tick();
      chk_pix("post_rst_pix", snap1(), 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
